// File: rtl/lsu_subword_if.sv
// ---------------------------------------------------------------------------
// lsu_subword_if
// Bundles the core-side request/response signals and the word-only memory
// port of the load/store unit.
//   Core side : req, is_store, size, sign_ext, addr, wdata  (to LSU)
//               busy, done, err, rdata                      (from LSU)
//   Memory    : mem_addr, mem_we, mem_wdata                 (from LSU)
//               mem_rdata                                   (to LSU)
// modport slave  : the LSU itself.
// modport master : the environment (core + memory) around the LSU.
// ---------------------------------------------------------------------------
interface lsu_subword_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  is_store;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req, is_store, size, sign_ext, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req, is_store, size, sign_ext, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_subword.sv
// ---------------------------------------------------------------------------
// lsu_subword
// Load/store unit between the core datapath and a word-only data memory.
// Byte/halfword/word loads with sign or zero extension; byte/halfword stores
// via read-modify-write, word stores written directly. Misaligned accesses
// and size=11 complete immediately with err=1 and no memory access.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lsu_subword_if.slave (request/response + memory port)
// ---------------------------------------------------------------------------
module lsu_subword #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  lsu_subword_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;

  state_e                state_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic                  is_store_q;
  logic [1:0]            size_q;
  logic                  sign_ext_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           old_q;

  logic                  misalign_d;
  logic [31:0]           load_d;
  logic [31:0]           merged_d;

  // Extract the addressed lane from a memory word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  lo,
                                           input logic [1:0]  sz,
                                           input logic        sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return sx ? 32'(b) : {24'b0, b};
      2'b01:   return sx ? 32'(h) : {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed lane of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  sz);
    logic [31:0] m;
    m = old;
    case (sz)
      2'b00:   m[{lo, 3'b000} +: 8]    = wd[7:0];
      2'b01:   m[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  always_comb begin
    misalign_d = 1'b0;
    case (bus.size)
      2'b01:   misalign_d = bus.addr[0];
      2'b10:   misalign_d = (bus.addr[1:0] != 2'b00);
      2'b11:   misalign_d = 1'b1;
      default: misalign_d = 1'b0;
    endcase
  end

  assign load_d   = load_ext(bus.mem_rdata, addr_q[1:0], size_q, sign_ext_q);
  assign merged_d = store_merge(old_q, wdata_q, addr_q[1:0], size_q);

  // Request capture and RMW old-word latch; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req) begin
      is_store_q <= bus.is_store;
      size_q     <= bus.size;
      sign_ext_q <= bus.sign_ext;
      addr_q     <= bus.addr;
      wdata_q    <= bus.wdata;
    end
    if (state_q == RD && is_store_q) begin
      old_q <= bus.mem_rdata;
    end
  end

  // Control FSM; rdata is reset as well because it is a visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            if (misalign_d) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              err_q   <= 1'b0;
              // Word stores skip the read; everything else reads first.
              state_q <= (bus.is_store && bus.size == 2'b10) ? WR : RD;
            end
          end
        end
        RD: begin
          if (is_store_q) begin
            state_q <= WR;
          end else begin
            rdata_q <= load_d;
            state_q <= FIN;
          end
        end
        WR:  state_q <= FIN;
        FIN: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.err       = (state_q == FIN) & err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = (state_q != IDLE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  // Reset gates the write strobe combinationally so an aborted WR never writes.
  assign bus.mem_we    = (state_q == WR) & ~rst;
  assign bus.mem_wdata = bus.mem_we ? merged_d : 32'h0;

endmodule

// File: tb/tb_lsu_subword.sv
module tb_lsu_subword;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lsu_subword_if #(.ADDR_WIDTH(32)) bus ();

  lsu_subword #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory model: combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  typedef struct { logic err; logic [31:0] rdata; int lat; int e0; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wexp_t;
  exp_t  sb_q[$];
  wexp_t wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done and every memory write.
  always @(negedge clk) begin
    exp_t  e;
    wexp_t w;
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb_q.pop_front();
        chk("done_err", {31'b0, bus.err}, {31'b0, e.err});
        chk("done_rdata", bus.rdata, e.rdata);
        chk("latency", cyc - e.e0 + 1, e.lat);
      end
    end
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", bus.mem_addr, w.addr);
        chk("wr_data", bus.mem_wdata, w.data);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       input logic push);
    wait_idle();
    bus.req = 1'b1; bus.is_store = st; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    if (push) sb_q.push_back('{e_err, e_rd, lat, cyc});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, bus.done}, 32'h0);
    chk({tag, "_err"}, {31'b0, bus.err}, 32'h0);
    chk({tag, "_rdata"}, bus.rdata, 32'h0);
    chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h11223344;   // 0x100
    mem[65] = 32'h11A2B344;   // 0x104
    bus.req = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Loads
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h11223344, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h105, 32'h0, 1'b0, 32'hFFFFFFB3, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h105, 32'h0, 1'b0, 32'h000000B3, 2, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b0, 32'h000011A2, 2, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 1'b0, 32'hFFFFB344, 2, 1'b1);

    // Stores: rdata must stay at the last load value
    wq.push_back('{32'h100, 32'h11EF3344});
    issue(1'b1, 2'b00, 1'b0, 32'h102, 32'hDEADBEEF, 1'b0, 32'hFFFFB344, 3, 1'b1);
    wait_idle();
    chk("mem_after_sb", mem[64], 32'h11EF3344);
    wq.push_back('{32'h100, 32'hCAFE3344});
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000CAFE, 1'b0, 32'hFFFFB344, 3, 1'b1);
    wait_idle();
    chk("mem_after_sh", mem[64], 32'hCAFE3344);
    wq.push_back('{32'h100, 32'hA5A5A5A5});
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A5A5A5, 1'b0, 32'hFFFFB344, 2, 1'b1);
    wait_idle();
    chk("mem_after_sw", mem[64], 32'hA5A5A5A5);

    // Misaligned / illegal: no memory access, rdata unchanged
    issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b1, 32'hFFFFB344, 1, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 1'b1, 32'hFFFFB344, 1, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFFB344, 1, 1'b1);
    wait_idle();
    chk("mem_after_err", mem[64], 32'hA5A5A5A5);

    // Reset during RD of a byte store aborts it
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000077, 1'b0, 32'h0, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_in_rd");
    repeat (3) @(negedge clk);
    chk("mem_after_abort", mem[64], 32'hA5A5A5A5);

    // req held high: second accept only on the edge after FIN
    wait_idle();
    bus.req = 1'b1; bus.is_store = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h100; bus.wdata = 32'h0;
    @(posedge clk);
    #1;
    e0 = cyc;
    sb_q.push_back('{1'b0, 32'hA5A5A5A5, 2, e0});
    sb_q.push_back('{1'b0, 32'hA5A5A5A5, 2, e0 + 3});
    repeat (3) @(posedge clk);
    #1;
    bus.req = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", sb_q.size(), 32'h0);
    chk("writes_empty", wq.size(), 32'h0);
    chk("mem_0x104_final", mem[65], 32'h11A2B344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the core datapath and the word-only data memory port (addr, we, wdata, rdata).
- The memory reads combinationally, writes on the clock edge, and ignores addr[1:0].
- This block is the initiator on that port. It performs byte, halfword and word loads with sign/zero extension.
- Byte and halfword stores use read-modify-write. Word stores are written directly.
- Requests use a req/done handshake; misaligned accesses are flagged and not performed.

Parameters:
ADDR_WIDTH, 32, byte-address width; the data width is fixed at 32.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req  input  1  request strobe; sampled only in IDLE
is_store  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  ADDR_WIDTH  byte address
wdata  input  32  store data; byte in [7:0], halfword in [15:0]
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = misaligned or illegal size
rdata  output  32  extended load result; holds until the next load completes
mem_addr  output  ADDR_WIDTH  {addr_q[ADDR_WIDTH-1:2],2'b00} while busy, 0 in IDLE
mem_we  output  1  memory write enable
mem_wdata  output  32  word to write; 0 when mem_we=0
mem_rdata  input  32  combinational read data from memory

Behaviour:
- States: IDLE, RD, WR, FIN.
- Reset values (next edge with rst=1): state IDLE; busy=0, done=0, err=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we = (state==WR) & ~rst. A reset in RD or WR aborts the access with no write.
- Accept: in IDLE with req=1, capture is_store, size, sign_ext, addr, wdata into *_q registers.
- req in any other state is ignored. No queuing.
- Alignment check at accept:
  - size=01 with addr[0]=1: error.
  - size=10 with addr[1:0]!=0: error.
  - size=11: error.
  - On error go to FIN with err=1 and make no memory access.
- Transitions after a legal accept:
  - Load: IDLE -> RD.
  - Store word: IDLE -> WR.
  - Store byte/halfword: IDLE -> RD.
- RD, load:
  - Lanes are little-endian. Byte lane = addr_q[1:0], bits [8*lane+7 : 8*lane]. Halfword lane = addr_q[1], bits [16*addr_q[1]+15 : 16*addr_q[1]]. Word = all 32 bits.
  - Extract the field from mem_rdata and extend per sign_ext. Word loads ignore sign_ext.
  - Register the result into rdata at the edge; go to FIN.
- RD, store:
  - Latch mem_rdata into old_q; go to WR.
- WR:
  - Merged word = old_q with the selected lane replaced by wdata_q[7:0] or wdata_q[15:0].
  - For a word store the merged word is wdata_q.
  - Drive mem_wdata = merged word and mem_we=1 for exactly one cycle; the memory writes at the WR exit edge. Go to FIN.
- FIN:
  - done=1 for one cycle. err as determined at accept, otherwise 0.
  - Go to IDLE. busy=0 from the next cycle, so a new req is accepted no earlier than the cycle after FIN.
- Latency, counted from the accepting edge E0 to the cycle in which done=1:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte/halfword store: 3 cycles.
- rdata changes only on a successful load's RD->FIN edge.
- err and done are 0 outside FIN.
- mem_addr is stable through RD, WR and FIN.

Test Plan:
1. Word load: preload mem[0x100]=0x11223344; lw 0x100 -> rdata=0x11223344, done 2 cycles after accept, err=0, mem_we never 1.
2. Sub-word loads: preload mem[0x104]=0x11A2B344.
   - lb 0x105 -> 0xFFFFFFB3.
   - lbu 0x105 -> 0x000000B3.
   - lh 0x106 -> 0x000011A2.
   - lh 0x104 -> 0xFFFFB344.
3. Byte store: mem[0x100]=0x11223344; sb 0x102 wdata=0xDEADBEEF -> exactly one mem_we cycle with mem_wdata=0x11EF3344; mem_addr=0x100; done 3 cycles after accept; readback 0x11EF3344.
4. Halfword and word stores:
   - sh 0x102 wdata=0x0000CAFE -> mem=0xCAFE3344, done after 3 cycles.
   - Then sw 0x100 wdata=0xA5A5A5A5 -> mem=0xA5A5A5A5, done after 2 cycles, no RD state.
5. Misaligned/illegal:
   - lh 0x101, sw 0x102 and size=11 -> each gives done and err=1 one cycle after accept.
   - mem_we stays 0, memory unchanged, rdata unchanged.
6. Reset and busy:
   - sb 0x100 with rst asserted for one cycle during RD -> no mem_we, memory unchanged, all outputs at reset values.
   - req held high while busy is accepted only after FIN; exactly one done per accept.
